// File: rtl/uart_tx_arb_if.sv
// Requester-side and uart_tx-side handshake bundle of the uart_tx packet arbiter.
// master = requesters + uart_tx side, slave = the arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*DATA_BITS-1:0] i_src_data;
  logic [NUM_SRC-1:0]           i_src_valid;
  logic [NUM_SRC-1:0]           i_src_last;
  logic [NUM_SRC-1:0]           o_src_ready;
  logic [DATA_BITS-1:0]         o_tx_data;
  logic                         o_tx_valid;
  logic                         i_tx_ready;
  logic [IDW-1:0]               o_grant_id;
  logic                         o_busy;
  logic                         o_abort;

  modport master (
    output i_src_data, i_src_valid, i_src_last, i_tx_ready,
    input  o_src_ready, o_tx_data, o_tx_valid, o_grant_id, o_busy, o_abort
  );

  modport slave (
    input  i_src_data, i_src_valid, i_src_last, i_tx_ready,
    output o_src_ready, o_tx_data, o_tx_valid, o_grant_id, o_busy, o_abort
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter sharing one uart_tx byte channel; each packet gets a 0xA<id> header.
// Define UART_TX_ARB_CSUM_EN to append an XOR checksum byte to every non-aborted packet.
module uart_tx_arb #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst,
  uart_tx_arb_if.slave bus
);
  localparam int unsigned IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef UART_TX_ARB_CSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;
`endif

  state_e               state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [TW-1:0]        tmo_q, tmo_d;
`ifdef UART_TX_ARB_CSUM_EN
  logic [DATA_BITS-1:0] csum_q, csum_d;
`endif

  logic                 src_valid_g;
  logic                 src_last_g;
  logic [DATA_BITS-1:0] src_data_g;
  logic                 tmo_hit;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       ptr_next;

  assign src_valid_g = bus.i_src_valid[grant_q];
  assign src_last_g  = bus.i_src_last[grant_q];
  assign src_data_g  = bus.i_src_data[grant_q*DATA_BITS +: DATA_BITS];
  assign tmo_hit     = (state_q == DATA) && !src_valid_g && (tmo_q == TMO_LAST);
  assign ptr_next    = IDW'((32'(grant_q) + 32'd1) % NUM_SRC);

  // First requester at or above ptr (wrapping); scanned downward so the nearest one wins.
  always_comb begin
    pick = ptr_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((32'(ptr_q) + NUM_SRC - 1 - i) % NUM_SRC);
      if (bus.i_src_valid[idx]) pick = idx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_q <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
`ifdef UART_TX_ARB_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
`ifdef UART_TX_ARB_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next state, grant, pointer, idle counter and checksum.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
`ifdef UART_TX_ARB_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.i_src_valid) begin
          grant_d = pick;
          tmo_d   = '0;
`ifdef UART_TX_ARB_CSUM_EN
          csum_d  = '0;
`endif
          state_d = HDR;
        end
      end
      HDR: begin
        if (bus.i_tx_ready) state_d = DATA;
      end
      DATA: begin
        if (src_valid_g) begin
          // A UART stall with valid high holds the idle counter.
          if (bus.i_tx_ready) begin
            tmo_d = '0;
`ifdef UART_TX_ARB_CSUM_EN
            csum_d = csum_q ^ src_data_g;
            if (src_last_g) state_d = CSUM;
`else
            if (src_last_g) begin
              state_d = IDLE;
              ptr_d   = ptr_next;
            end
`endif
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`ifdef UART_TX_ARB_CSUM_EN
      CSUM: begin
        if (bus.i_tx_ready) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; DATA passes the granted source straight through.
  always_comb begin
    bus.o_tx_valid  = 1'b0;
    bus.o_tx_data   = '0;
    bus.o_src_ready = '0;
    case (state_q)
      HDR: begin
        bus.o_tx_valid = 1'b1;
        bus.o_tx_data  = DATA_BITS'({4'hA, 4'(grant_q)});
      end
      DATA: begin
        bus.o_tx_valid           = src_valid_g;
        bus.o_tx_data            = src_data_g;
        bus.o_src_ready[grant_q] = bus.i_tx_ready;
      end
`ifdef UART_TX_ARB_CSUM_EN
      CSUM: begin
        bus.o_tx_valid = 1'b1;
        bus.o_tx_data  = csum_q;
      end
`endif
      default: ;
    endcase
  end

  assign bus.o_grant_id = grant_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_abort    = tmo_hit;
endmodule
